// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the seven-segment loop-back capture block:
//   digit count and width, the digit-byte type, the capture FSM state
//   encoding and the digit-select classification helpers.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 8;
  localparam int DIG_IDX_W  = $clog2(NUM_DIGITS);

  typedef logic [SEG_W-1:0] digit_t;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HELD   = 1'b1
  } cap_state_t;

  typedef enum logic [1:0] {
    COM_BLANK  = 2'd0,
    COM_ONEHOT = 2'd1,
    COM_BAD    = 2'd2
  } com_class_t;

  // Classify a normalised (1 = selected) digit-select vector.
  function automatic com_class_t classify_com(input logic [NUM_DIGITS-1:0] com);
    if (com == '0) return COM_BLANK;
    // Clearing the lowest set bit leaves zero only for a single set bit.
    if ((com & (com - NUM_DIGITS'(1))) == '0) return COM_ONEHOT;
    return COM_BAD;
  endfunction

  // Index of the set bit of a one-hot vector (meaningless otherwise).
  function automatic logic [DIG_IDX_W-1:0] onehot_index(input logic [NUM_DIGITS-1:0] com);
    logic [DIG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (com[i]) idx = DIG_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// seg_stable_filter
//   Registers the raw bus once and measures how long the registered value
//   has stayed unchanged.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   pins         raw {com, ens} bus
//   pair         registered {com, ens}
//   stable_hit   one-cycle pulse the cycle after the count reaches STABLE_CYC
//   pair_changed high the cycle after the registered pair took a new value
module seg_stable_filter #(
  parameter int W          = 16,
  parameter int STABLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pins,
  output logic [W-1:0] pair,
  output logic         stable_hit,
  output logic         pair_changed
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  logic [W-1:0]     pair_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             hit_reg;
  logic             changed_reg;
  logic             same;

  // The value about to be registered equals the current pair, so the pair
  // will be unchanged across this edge.
  assign same = (pins == pair_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_reg    <= '0;
      cnt_reg     <= '0;
      hit_reg     <= 1'b0;
      changed_reg <= 1'b0;
    end else begin
      pair_reg    <= pins;
      changed_reg <= !same;
      // Fires exactly once per stable episode: only on the step into saturation.
      hit_reg     <= same && (cnt_reg == CNT_MAX - CNT_W'(1));
      if (!same) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pair         = pair_reg;
  assign stable_hit   = hit_reg;
  assign pair_changed = changed_reg;

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Loop-back monitor for the multiplexed seven-segment bus. Rebuilds the
//   per-digit segment bytes from the scan, rejecting inter-digit glitches.
// Ports:
//   clk        system clock
//   nrst       asynchronous active-high reset (despite the name)
//   oS_COM     observed digit-select lines
//   oS_ENS     observed segment lines
//   seg_out    digit k byte in bits [8k+7:8k]
//   seg_valid  bit k set once digit k has been captured
//   frame_done one-cycle pulse when the last missing digit of a frame lands
//   com_err    one-cycle pulse on a stable, non-blank, non-one-hot select
//   stale      watchdog flag
// Optional feature: define SEVEN_SEG_CAPTURE_TIMEOUT_EN to build the stale
//   watchdog; without it stale is tied low.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYC     = 4,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_CYC    = 65536
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [NUM_DIGITS-1:0]       oS_COM,
  input  logic [SEG_W-1:0]            oS_ENS,
  output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
  output logic [NUM_DIGITS-1:0]       seg_valid,
  output logic                        frame_done,
  output logic                        com_err,
  output logic                        stale
);

  localparam int PAIR_W = NUM_DIGITS + SEG_W;

  logic [PAIR_W-1:0]     pair;
  logic                  stable_hit;
  logic                  pair_changed;
  logic [NUM_DIGITS-1:0] com_norm;
  digit_t                ens;
  com_class_t            com_class;
  logic                  do_write;
  logic                  wd_expire;
  logic [NUM_DIGITS-1:0] mask_or;

  cap_state_t            state_reg, state_next;
  digit_t                seg_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_reg, valid_next;
  logic [NUM_DIGITS-1:0] mask_reg, mask_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  com_err_reg, com_err_next;

  seg_stable_filter #(
    .W          (PAIR_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk          (clk),
    .rst          (nrst),
    .pins         ({oS_COM, oS_ENS}),
    .pair         (pair),
    .stable_hit   (stable_hit),
    .pair_changed (pair_changed)
  );

  assign com_norm  = COM_ACTIVE_LOW ? ~pair[PAIR_W-1 -: NUM_DIGITS] : pair[PAIR_W-1 -: NUM_DIGITS];
  assign ens       = pair[SEG_W-1:0];
  assign com_class = classify_com(com_norm);
  assign do_write  = (state_reg == ST_SETTLE) && stable_hit && (com_class == COM_ONEHOT);
  // com_norm is the one-hot digit bit itself when a write happens.
  assign mask_or   = mask_reg | com_norm;

  always_comb begin
    state_next      = state_reg;
    valid_next      = valid_reg;
    mask_next       = mask_reg;
    frame_done_next = 1'b0;
    com_err_next    = 1'b0;
    case (state_reg)
      ST_SETTLE: begin
        if (stable_hit) begin
          state_next = ST_HELD;
          case (com_class)
            COM_ONEHOT: begin
              valid_next = valid_reg | com_norm;
              if (&mask_or) begin
                frame_done_next = 1'b1;
                mask_next       = '0;
              end else begin
                mask_next = mask_or;
              end
            end
            COM_BAD: com_err_next = 1'b1;
            default: ;
          endcase
        end
      end
      ST_HELD: begin
        if (pair_changed) state_next = ST_SETTLE;
      end
      default: state_next = ST_SETTLE;
    endcase
    // wd_expire never coincides with a write, so the write path above is intact.
    if (wd_expire) begin
      valid_next = '0;
      mask_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_reg      <= ST_SETTLE;
      valid_reg      <= '0;
      mask_reg       <= '0;
      frame_done_reg <= 1'b0;
      com_err_reg    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) seg_reg[i] <= '0;
    end else begin
      state_reg      <= state_next;
      valid_reg      <= valid_next;
      mask_reg       <= mask_next;
      frame_done_reg <= frame_done_next;
      com_err_reg    <= com_err_next;
      if (do_write) seg_reg[onehot_index(com_norm)] <= ens;
    end
  end

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            stale_reg;

  assign wd_expire = !do_write && (wd_cnt_reg == WD_LAST);

  // Counter parks at its last value while stale, re-clearing valid each cycle.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      wd_cnt_reg <= '0;
      stale_reg  <= 1'b0;
    end else if (do_write) begin
      wd_cnt_reg <= '0;
      stale_reg  <= 1'b0;
    end else if (wd_expire) begin
      stale_reg  <= 1'b1;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  assign stale = stale_reg;
`else
  assign wd_expire = 1'b0;
  assign stale     = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
      assign seg_out[gi*SEG_W +: SEG_W] = seg_reg[gi];
    end
  endgenerate

  assign seg_valid  = valid_reg;
  assign frame_done = frame_done_reg;
  assign com_err    = com_err_reg;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
//   Directed and randomized stimulus for seven_seg_capture, checked every
//   cycle against a run-length reference model of the capture rules.
module tb_seven_seg_capture;

  localparam int STABLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 32;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  com_pins;
  logic [7:0]  ens_pins;
  logic [63:0] seg_out;
  logic [7:0]  seg_valid;
  logic        frame_done;
  logic        com_err;
  logic        stale;

  seven_seg_capture #(
    .STABLE_CYC     (STABLE_CYC),
    .COM_ACTIVE_LOW (1'b1),
    .TIMEOUT_CYC    (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .oS_COM     (com_pins),
    .oS_ENS     (ens_pins),
    .seg_out    (seg_out),
    .seg_valid  (seg_valid),
    .frame_done (frame_done),
    .com_err    (com_err),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int err_count = 0;

  // Reference model: a stable run of STABLE_CYC+1 identical samples
  // triggers one action on the following edge.
  logic [7:0]  m_seg [8];
  logic [7:0]  m_valid, m_mask;
  logic        m_fd, m_err, m_stale;
  logic [15:0] last_pair;
  int          run_len;
  int          idle;

  function automatic logic [63:0] m_flat();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = m_seg[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_seg[k] = 8'h00;
    m_valid = 8'h00; m_mask = 8'h00;
    m_fd = 1'b0; m_err = 1'b0; m_stale = 1'b0;
    last_pair = 16'h0000;   // input register resets to zero
    run_len = 1;
    idle = 0;
  endtask

  task automatic model_edge();
    logic [7:0] sel;
    int n_sel;
    bit wrote;
    m_fd = 1'b0; m_err = 1'b0; wrote = 0;
    if (run_len == STABLE_CYC + 1) begin
      sel = ~last_pair[15:8];
      n_sel = $countones(sel);
      if (n_sel == 1) begin
        for (int k = 0; k < 8; k++) begin
          if (sel[k]) begin
            m_seg[k] = last_pair[7:0];
            m_valid[k] = 1'b1;
            m_mask[k] = 1'b1;
          end
        end
        wrote = 1;
        if (m_mask == 8'hFF) begin
          m_fd = 1'b1;
          m_mask = 8'h00;
        end
      end else if (n_sel > 1) begin
        m_err = 1'b1;
      end
    end
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    if (wrote) begin
      idle = 0; m_stale = 1'b0;
    end else begin
      idle++;
      if (idle >= TIMEOUT_CYC) begin
        m_stale = 1'b1; m_valid = 8'h00; m_mask = 8'h00;
      end
    end
`endif
    if ({com_pins, ens_pins} == last_pair) begin
      run_len++;
    end else begin
      last_pair = {com_pins, ens_pins};
      run_len = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".seg_out"},    seg_out,           m_flat());
    chk({tag, ".seg_valid"},  64'(seg_valid),    64'(m_valid));
    chk({tag, ".frame_done"}, 64'(frame_done),   64'(m_fd));
    chk({tag, ".com_err"},    64'(com_err),      64'(m_err));
    chk({tag, ".stale"},      64'(stale),        64'(m_stale));
    if (frame_done === 1'b1) fd_count++;
    if (com_err === 1'b1) err_count++;
    $display("t=%0t %s com=%h ens=%h seg_out=%h valid=%h fd=%b err=%b stale=%b",
             $time, tag, com_pins, ens_pins, seg_out, seg_valid, frame_done, com_err, stale);
  endtask

  task automatic step(input string tag, input logic [7:0] c, input logic [7:0] e);
    com_pins = c;
    ens_pins = e;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic hold(input string tag, input logic [7:0] c, input logic [7:0] e, input int n);
    for (int i = 0; i < n; i++) step(tag, c, e);
  endtask

  task automatic show_digit(input int k, input logic [7:0] e, input int n);
    logic [7:0] one;
    one = 8'h01 << k;
    hold("digit", ~one, e, n);
  endtask

  task automatic do_reset();
    com_pins = 8'hFF;
    ens_pins = 8'h00;
    nrst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #3;
    nrst = 1'b0;
  endtask

  initial begin
    logic [63:0] seg_snap;
    int base;
    logic [7:0] c, e;
    int n;

    nrst = 1'b0;
    com_pins = 8'hFF;
    ens_pins = 8'h00;
    #2;

    // 1: first capture latency
    do_reset();
    hold("t1", 8'hFE, 8'hC0, 5);
    chk("t1_before_latency", 64'(seg_out[7:0]), 64'h00);
    step("t1", 8'hFE, 8'hC0);
    chk("t1_byte0", 64'(seg_out[7:0]), 64'hC0);
    chk("t1_valid", 64'(seg_valid), 64'h01);

    // 2: full scan
    do_reset();
    fd_count = 0;
    for (int k = 0; k < 8; k++) show_digit(k, 8'h01 << k, 6);
    chk("t2_frame_pulses", 64'(fd_count), 64'd1);
    chk("t2_valid", 64'(seg_valid), 64'hFF);
    chk("t2_seg_out", seg_out, 64'h8040201008040201);

    // 3: inter-digit glitch, then the same pattern held
    do_reset();
    err_count = 0;
    show_digit(0, 8'h11, 6);
    hold("glitch", 8'hFC, 8'h11, 2);
    show_digit(1, 8'h22, 6);
    chk("t3_glitch_err", 64'(err_count), 64'd0);
    chk("t3_glitch_valid", 64'(seg_valid), 64'h03);
    seg_snap = seg_out;
    hold("badcom", 8'hFC, 8'h22, 6);
    chk("t3_bad_err", 64'(err_count), 64'd1);
    chk("t3_bad_nowrite", seg_out, seg_snap);

    // 4: recapture within a frame
    do_reset();
    fd_count = 0;
    show_digit(3, 8'h33, 6);
    show_digit(3, 8'h3C, 6);
    for (int k = 0; k < 8; k++) begin
      if (k != 3) begin
        chk("t4_no_early_frame", 64'(fd_count), 64'd0);
        show_digit(k, 8'hA0 + 8'(k), 6);
      end
    end
    chk("t4_digit3", 64'(seg_out[31:24]), 64'h3C);
    chk("t4_frame_pulses", 64'(fd_count), 64'd1);

    // 5: reset mid-settle
    do_reset();
    show_digit(2, 8'h5A, 6);
    show_digit(5, 8'h77, 2);
    nrst = 1'b1;
    #1;
    model_reset();
    check_all("midreset");
    chk("t5_seg_zero", seg_out, 64'h0);
    @(posedge clk);
    #3;
    nrst = 1'b0;
    show_digit(5, 8'h77, 5);
    chk("t5_no_early_write", 64'(seg_valid), 64'h00);
    show_digit(5, 8'h77, 1);
    chk("t5_resettle_write", 64'(seg_valid), 64'h20);

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    // 6: watchdog
    do_reset();
    show_digit(4, 8'h4D, 6);
    seg_snap = seg_out;
    hold("idle", 8'hFF, 8'h00, TIMEOUT_CYC);
    chk("t6_stale", 64'(stale), 64'd1);
    chk("t6_valid_cleared", 64'(seg_valid), 64'h00);
    chk("t6_seg_kept", seg_out, seg_snap);
    show_digit(6, 8'h66, 6);
    chk("t6_stale_cleared", 64'(stale), 64'd0);
`endif

    // 7: randomized episodes
    do_reset();
    for (int ep = 0; ep < 80; ep++) begin
      base = int'($urandom_range(0, 9));
      if (base < 7) begin
        c = ~(8'h01 << $urandom_range(0, 7));
      end else if (base == 7) begin
        c = 8'hFF;
      end else begin
        c = 8'($urandom);
      end
      e = 8'($urandom);
      n = int'($urandom_range(1, 8));
      hold("rand", c, e, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side decoder for the multiplexed seven-segment bus that the display scan controller drives.
- Watches the digit-select (`oS_COM`) and segment (`oS_ENS`) lines.
- Rejects the transition glitches that occur between digits.
- Rebuilds the eight per-digit segment bytes, with per-digit valid flags and a frame-complete strobe.
- Sits beside the display path as a loop-back monitor; lets the bench and on-chip self-check read back what the game logic actually displayed.

## Interface
Parameters:
- `STABLE_CYC`, 4: consecutive identical samples required before a digit is accepted (≥2).
- `COM_ACTIVE_LOW`, 1: 1 = selected digit drives its `oS_COM` bit low; 0 = high.
- `TIMEOUT_CYC`, 65536: stale-watchdog period; used only with `SEVEN_SEG_CAPTURE_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single system clock.
- `nrst`, input, 1: **reset, asynchronous and active-high**.
- `oS_COM`, input, 8: observed digit-select lines.
- `oS_ENS`, input, 8: observed segment lines.
- `seg_out`, output, 64: digit *k* segment byte in bits [8k+7:8k].
- `seg_valid`, output, 8: bit *k* set once digit *k* has been captured.
- `frame_done`, output, 1: one-cycle pulse when every digit has been captured since the last pulse.
- `com_err`, output, 1: one-cycle pulse on a stable, non-blank, non-one-hot `oS_COM`.
- `stale`, output, 1: watchdog flag; constant 0 when the feature is compiled out.

## Operation
- Inputs are registered once; all decisions use the registered pair {com, ens}.
- Normalise com: if `COM_ACTIVE_LOW`, invert, so a 1 means "selected".
- Stability counter:
  - Clears whenever the registered pair differs from the previous cycle's pair.
  - Otherwise increments and saturates at `STABLE_CYC`.
- FSM states:
  - **SETTLE** (reset state): waiting for stability. When the count reaches `STABLE_CYC`, classify normalised com:
    - one-hot: write ens to digit k, set `seg_valid[k]` and frame-mask bit k, go to HELD.
    - all zeros (blank): go to HELD, no write, no error.
    - anything else: pulse `com_err`, go to HELD.
  - **HELD**: no further action while the pair is unchanged. Any change returns to SETTLE. One stable episode produces at most one write or one error.
- Frame mask:
  - When the write of the last missing digit completes the mask, pulse `frame_done` in that same cycle and clear the mask.
  - Re-capturing an already-set digit within a frame overwrites its byte but does not advance the frame.
- `seg_out` holds its value between writes; blank periods never clear it.

## Timing
- Reset values: `seg_out`=0, `seg_valid`=0, frame mask=0, `frame_done`=0, `com_err`=0, `stale`=0, FSM=SETTLE, counter=0.
- Latency: a pin change sampled at edge 0 appears in `seg_out` after edge `STABLE_CYC`+1, provided the pins stay steady throughout.
- A pattern held for fewer than `STABLE_CYC` samples is never written.
- Reset asserted mid-settle or mid-frame: everything returns to reset values immediately; no partial write.
- On the capture edge, `frame_done` and the write become visible together.

## Configuration
- `SEVEN_SEG_CAPTURE_TIMEOUT_EN` defined:
  - A counter clears on every successful digit write.
  - When it reaches `TIMEOUT_CYC`-1 without a write: set `stale`, clear `seg_valid` and the frame mask; `seg_out` is retained.
  - The next write clears `stale`.
- Macro undefined: no watchdog logic is built and `stale` is tied to 0.

## Structure
- Package `seven_seg_pkg` holds:
  - `NUM_DIGITS`=8 and `SEG_W`=8;
  - the digit-byte type;
  - the FSM state encoding (SETTLE, HELD);
  - the shared one-hot/blank classification function.
- Sub-module `seg_stable_filter` contains the input register, change detector and saturating counter. It outputs the registered pair and a one-cycle `stable_hit` pulse.

## Test plan
- Reset, then drive com=8'b1111_1110, ens=8'hC0 steady. Expect `seg_out[7:0]`=C0 and `seg_valid`=01 after edge 5, with `STABLE_CYC`=4.
- Scan all 8 digits at 6 cycles each with values 8'h01 to 8'h80. Expect exactly one `frame_done` pulse, on digit 7's capture cycle; `seg_valid`=FF; `seg_out`=64'h8040201008040201.
- Insert a 2-cycle glitch com=8'b1111_1100 between digits. Expect no write and no `com_err`. Hold the same pattern 6 cycles: expect one `com_err` pulse and no write.
- Capture digit 3 twice, then the other seven digits once. Expect digit 3 holds the second value and `frame_done` pulses only after the eighth distinct digit.
- Assert `nrst` two cycles into a settle. Expect all outputs 0 and no write after release until a full `STABLE_CYC` re-settle.
- With `SEVEN_SEG_CAPTURE_TIMEOUT_EN` and `TIMEOUT_CYC`=32, stop scanning for 32 cycles. Expect `stale`=1, `seg_valid`=0, `seg_out` unchanged; the next capture clears `stale`.
